// File: rtl/postfix_pkg.sv
// Shared codes for the postfix evaluator: token kinds, operator codes and FSM states.
// The optional divider is enabled by defining POSTFIX_DIV_EN.
package postfix_pkg;

  typedef enum logic [1:0] {
    TK_NUM = 2'b00,
    TK_OP  = 2'b01,
    TK_END = 2'b10,
    TK_CLR = 2'b11
  } tok_kind_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_code_e;

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/postfix_if.sv
// Token-in / result-out bundle between the postfix token source and the evaluator.
// master = token source / display side, slave = evaluator.
interface postfix_if #(
  parameter int W     = 16,
  parameter int DEPTH = 8
);
  logic                     tok_valid;
  logic                     tok_ready;
  logic [1:0]               tok_kind;
  logic [W-1:0]             tok_data;
  logic                     res_valid;
  logic [W-1:0]             res_data;
  logic                     res_err;
  logic [$clog2(DEPTH):0]   depth;

  modport master (
    output tok_valid, tok_kind, tok_data,
    input  tok_ready, res_valid, res_data, res_err, depth
  );

  modport slave (
    input  tok_valid, tok_kind, tok_data,
    output tok_ready, res_valid, res_data, res_err, depth
  );
endinterface

// File: rtl/postfix_iter_alu.sv
// W-cycle iterative multiplier (shift-add, low W bits); with POSTFIX_DIV_EN also a
// restoring signed divider sharing the same registers and iteration counter.
module postfix_iter_alu
  import postfix_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         div0
);
  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          busy_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  x_reg, y_reg, acc_reg;
  logic [W-1:0]  x_next, y_next, acc_next;

`ifdef POSTFIX_DIV_EN
  logic         div_reg, neg_reg, div0_reg;
  logic [W:0]   rem_shift, rem_diff;
  logic [W-1:0] abs_a, abs_b;

  assign abs_a = a[W-1] ? -a : a;
  assign abs_b = b[W-1] ? -b : b;
`else
  logic op_unused;
  assign op_unused = ^op;
`endif

  // One iteration step; the final step is consumed combinationally in the done cycle.
  always_comb begin
    acc_next = acc_reg + (y_reg[0] ? x_reg : '0);
    x_next   = x_reg << 1;
    y_next   = y_reg >> 1;
`ifdef POSTFIX_DIV_EN
    rem_shift = {acc_reg, y_reg[W-1]};
    rem_diff  = rem_shift - {1'b0, x_reg};
    if (div_reg) begin
      x_next = x_reg;
      if (rem_shift >= {1'b0, x_reg}) begin
        acc_next = rem_diff[W-1:0];
        y_next   = {y_reg[W-2:0], 1'b1};
      end else begin
        acc_next = rem_shift[W-1:0];
        y_next   = {y_reg[W-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
      acc_reg  <= '0;
`ifdef POSTFIX_DIV_EN
      div_reg  <= 1'b0;
      neg_reg  <= 1'b0;
      div0_reg <= 1'b0;
`endif
    end else if (start) begin
      busy_reg <= 1'b1;
      cnt_reg  <= '0;
      acc_reg  <= '0;
`ifdef POSTFIX_DIV_EN
      div_reg  <= (op == OP_DIV);
      neg_reg  <= a[W-1] ^ b[W-1];
      div0_reg <= (b == '0);
      x_reg    <= (op == OP_DIV) ? abs_b : a;
      y_reg    <= (op == OP_DIV) ? abs_a : b;
`else
      x_reg    <= a;
      y_reg    <= b;
`endif
    end else if (busy_reg) begin
      x_reg   <= x_next;
      y_reg   <= y_next;
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + CW'(1);
      if (done) busy_reg <= 1'b0;
    end
  end

  assign busy = busy_reg;
  assign done = busy_reg && (cnt_reg == LAST);

`ifdef POSTFIX_DIV_EN
  assign result = div_reg ? (neg_reg ? -y_next : y_next) : acc_next;
  assign div0   = div_reg && div0_reg;
`else
  assign result = acc_next;
  assign div0   = 1'b0;
`endif

endmodule

// File: rtl/postfix_evaluator.sv
// Stack-machine evaluator for postfix calculator tokens; MUL (and DIV when
// POSTFIX_DIV_EN is defined) stall the token stream for W cycles.
module postfix_evaluator
  import postfix_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input logic      clk,
  input logic      rst,
  postfix_if.slave bus
);
  localparam int            AW   = $clog2(DEPTH);
  localparam int            DW   = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [1:0]    state_reg;
  logic          run_reg;
  logic          err_reg;
  logic [DW-1:0] sp_reg;
  logic [W-1:0]  res_data_reg;
  logic          res_err_reg;
  logic [W-1:0]  stack_reg [DEPTH];

  logic          tok_ready, accept, num_push, op_go;
  logic [1:0]    tok_op;
  logic [AW-1:0] top_idx, nxt_idx, wr_idx;
  logic [W-1:0]  op_a, op_b, wr_data;
  logic          wr_en;
  logic          alu_start, alu_busy, alu_done, alu_div0;
  logic [W-1:0]  alu_result;

  // run_reg keeps tok_ready low until the first edge after reset releases.
  assign tok_ready = run_reg && (state_reg == ST_ACC) && !alu_busy;
  assign accept    = bus.tok_valid && tok_ready;
  assign tok_op    = bus.tok_data[1:0];
  assign top_idx   = sp_reg[AW-1:0] - AW'(1);
  assign nxt_idx   = sp_reg[AW-1:0] - AW'(2);
  assign op_b      = stack_reg[top_idx];
  assign op_a      = stack_reg[nxt_idx];
  assign num_push  = accept && (bus.tok_kind == TK_NUM) && !err_reg && (sp_reg != FULL);
  assign op_go     = accept && (bus.tok_kind == TK_OP) && !err_reg && (sp_reg >= DW'(2));

`ifdef POSTFIX_DIV_EN
  assign alu_start = op_go && ((tok_op == OP_MUL) || (tok_op == OP_DIV));
`else
  assign alu_start = op_go && (tok_op == OP_MUL);
`endif

  postfix_iter_alu #(.W(W)) u_alu (
    .clk    (clk),
    .rst    (rst),
    .start  (alu_start),
    .a      (op_a),
    .b      (op_b),
    .op     (tok_op),
    .busy   (alu_busy),
    .done   (alu_done),
    .result (alu_result),
    .div0   (alu_div0)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sp_reg[AW-1:0];
    wr_data = bus.tok_data;
    if (state_reg == ST_ITER) begin
      if (alu_done && !alu_div0) begin
        wr_en   = 1'b1;
        wr_idx  = nxt_idx;
        wr_data = alu_result;
      end
    end else if (num_push) begin
      wr_en = 1'b1;
    end else if (op_go && (tok_op == OP_ADD || tok_op == OP_SUB)) begin
      wr_en   = 1'b1;
      wr_idx  = nxt_idx;
      wr_data = (tok_op == OP_ADD) ? (op_a + op_b) : (op_a - op_b);
    end
  end

  // Stack contents need no reset; occupancy is tracked by sp_reg.
  always_ff @(posedge clk) begin
    if (wr_en) stack_reg[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_ACC;
      run_reg      <= 1'b0;
      err_reg      <= 1'b0;
      sp_reg       <= '0;
      res_data_reg <= '0;
      res_err_reg  <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        ST_ACC: if (accept) begin
          case (bus.tok_kind)
            TK_NUM: if (!err_reg) begin
              if (sp_reg == FULL) err_reg <= 1'b1;
              else                sp_reg  <= sp_reg + DW'(1);
            end
            TK_OP: if (!err_reg) begin
              if (sp_reg < DW'(2))                            err_reg   <= 1'b1;
              else if (alu_start)                             state_reg <= ST_ITER;
              else if (tok_op == OP_ADD || tok_op == OP_SUB)  sp_reg    <= sp_reg - DW'(1);
              else                                            err_reg   <= 1'b1;
            end
            TK_END: begin
              state_reg <= ST_RESP;
              if (!err_reg && sp_reg == DW'(1)) begin
                res_data_reg <= op_b;
                res_err_reg  <= 1'b0;
              end else begin
                res_data_reg <= '0;
                res_err_reg  <= 1'b1;
              end
              sp_reg  <= '0;
              err_reg <= 1'b0;
            end
            TK_CLR: begin
              sp_reg  <= '0;
              err_reg <= 1'b0;
            end
          endcase
        end
        ST_ITER: if (alu_done) begin
          state_reg <= ST_ACC;
          if (alu_div0) err_reg <= 1'b1;
          else          sp_reg  <= sp_reg - DW'(1);
        end
        ST_RESP: state_reg <= ST_ACC;
        default: state_reg <= ST_ACC;
      endcase
    end
  end

  assign bus.tok_ready = tok_ready;
  assign bus.res_valid = (state_reg == ST_RESP);
  assign bus.res_data  = res_data_reg;
  assign bus.res_err   = res_err_reg;
  assign bus.depth     = sp_reg;

endmodule

// File: tb/tb_postfix_evaluator.sv
// Directed bench for postfix_evaluator: END responses are scoreboarded through a queue,
// stalls/depth/reset behaviour checked inline. Covers POSTFIX_DIV_EN when defined.
module tb_postfix_evaluator;
  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  postfix_if #(.W(W), .DEPTH(DEPTH)) bus ();

  postfix_evaluator #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Result monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.res_valid === 1'b1) begin
      $display("result: data=%h err=%b", bus.res_data, bus.res_err);
      chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e.data));
        chk("res_err", 32'(bus.res_err), 32'(e.err));
      end
    end
  end

  task automatic send(input logic [1:0] kind, input logic [W-1:0] data);
    int waited = 0;
    bus.tok_valid = 1'b1;
    bus.tok_kind  = kind;
    bus.tok_data  = data;
    @(negedge clk);
    while (!bus.tok_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    chk("accept_in_time", 32'(waited < 200), 32'd1);
    @(posedge clk);
    #1;
    bus.tok_valid = 1'b0;
  endtask

  task automatic t_num(input logic [W-1:0] v);
    send(2'b00, v);
  endtask

  task automatic t_op(input logic [1:0] c);
    send(2'b01, {{(W-2){1'b0}}, c});
  endtask

  task automatic t_clr();
    send(2'b11, '0);
  endtask

  // Iterative op: tok_ready must stay low for exactly W cycles after acceptance.
  task automatic t_iter(input logic [1:0] c, input string tag);
    int stall = 0;
    t_op(c);
    while (!bus.tok_ready && stall < 100) begin
      stall++;
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(stall), 32'(W));
  endtask

  task automatic t_end(input logic [W-1:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
    send(2'b10, '0);
    chk("resp_ready_low", 32'(bus.tok_ready), 32'd0);
    chk("resp_depth_cleared", 32'(bus.depth), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.tok_valid = 1'b0;
    bus.tok_kind  = 2'b00;
    bus.tok_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tok_ready", 32'(bus.tok_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_err", 32'(bus.res_err), 32'd0);
    chk("rst_depth", 32'(bus.depth), 32'd0);
    rst = 1'b0;
    chk("ready_before_first_edge", 32'(bus.tok_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", 32'(bus.tok_ready), 32'd1);

    // 80 25 MUL 234 SUB 3 70 MUL ADD END -> 1976
    t_num(16'd80);
    t_num(16'd25);
    t_iter(2'd2, "mul_stall_a");
    t_num(16'd234);
    t_op(2'd1);
    t_num(16'd3);
    t_num(16'd70);
    t_iter(2'd2, "mul_stall_b");
    chk("depth_before_add", 32'(bus.depth), 32'd2);
    t_op(2'd0);
    chk("depth_after_add", 32'(bus.depth), 32'd1);
    t_end(16'd1976, 1'b0);

    // subtraction to negative and additive wrap
    t_num(16'd5);
    t_num(16'd7);
    t_op(2'd1);
    t_end(16'hFFFE, 1'b0);
    t_num(16'h7FFF);
    t_num(16'h0001);
    t_op(2'd0);
    t_end(16'h8000, 1'b0);

    // underflow, discard while in error, recovery
    t_op(2'd0);
    t_num(16'd4);
    chk("discard_in_err", 32'(bus.depth), 32'd0);
    t_end(16'd0, 1'b1);
    t_num(16'd2);
    t_num(16'd3);
    t_op(2'd0);
    t_end(16'd5, 1'b0);

    // overflow, then a full stack reduced by ADDs
    for (int i = 0; i <= DEPTH; i++) t_num(W'(i + 1));
    chk("depth_full_overflow", 32'(bus.depth), 32'(DEPTH));
    t_end(16'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++) t_num(W'(i + 1));
    chk("depth_full", 32'(bus.depth), 32'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) t_op(2'd0);
    t_end(W'(DEPTH * (DEPTH + 1) / 2), 1'b0);

    // leftover operands, and CLR without strobe
    t_num(16'd9);
    t_num(16'd4);
    t_end(16'd0, 1'b1);
    t_num(16'd9);
    t_num(16'd4);
    t_clr();
    chk("depth_after_clr", 32'(bus.depth), 32'd0);
    t_num(16'd6);
    t_end(16'd6, 1'b0);

    // reset during a MUL iteration
    t_num(16'd2);
    t_num(16'd3);
    t_op(2'd2);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_tok_ready", 32'(bus.tok_ready), 32'd0);
    chk("abort_depth", 32'(bus.depth), 32'd0);
    chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_abort", 32'(bus.tok_ready), 32'd1);
    t_num(16'd2);
    t_num(16'd3);
    t_iter(2'd2, "mul_stall_c");
    t_end(16'd6, 1'b0);

`ifdef POSTFIX_DIV_EN
    t_num(16'hFFF9);
    t_num(16'd2);
    t_iter(2'd3, "div_stall");
    t_end(16'hFFFD, 1'b0);
    t_num(16'd1);
    t_num(16'd0);
    t_iter(2'd3, "div0_stall");
    t_end(16'd0, 1'b1);
`else
    t_num(16'd7);
    t_num(16'd2);
    t_op(2'd3);
    chk("div_no_stall", 32'(bus.tok_ready), 32'd1);
    t_end(16'd0, 1'b1);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
